// File: rtl/palette_lookup_arbiter.sv
// Round-robin shared palette lookup: NUM_REQ sprite layers, 2-stage registered lookup, one-hot tagged response.
// Optional transparency flag on the response is built only when PAL_XPARENT_EN is defined.
module palette_lookup_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 8,
    parameter int COLOR_W     = 12,
    parameter int XPARENT_IDX = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         pal_index,
    input  logic [COLOR_W-1:0]       pal_rgb,
    output logic                     rsp_valid,
    output logic [NUM_REQ-1:0]       rsp_tag,
    output logic [COLOR_W-1:0]       rsp_rgb,
    output logic                     rsp_xparent
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || XPARENT_IDX < 0 || XPARENT_IDX >= (1 << IDX_W)) begin : g_bad_param
        $error("palette_lookup_arbiter: parameter out of range");
    end

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [NUM_REQ-1:0] s1_tag_q, s1_tag_d;
    logic [IDX_W-1:0]   pal_index_q, pal_index_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] rsp_tag_q, rsp_tag_d;
    logic [COLOR_W-1:0] rsp_rgb_q, rsp_rgb_d;
    logic               rsp_xparent_q, rsp_xparent_d;

    logic [IDX_W-1:0]   idx_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;
    logic [PTR_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   grant_index;
    logic               accept;
    logic [PTR_W-1:0]   ptr_inc;
    logic               xp_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_arr[i] = req_index[i*IDX_W +: IDX_W];
        end
    end

    // Scan from rr_ptr upward (mod NUM_REQ); first valid layer wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        sum         = '0;
        cand        = '0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_index = '0;
        accept      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!accept && req_valid[cand]) begin
                accept         = 1'b1;
                grant_idx      = cand;
                grant_index    = idx_arr[cand];
                grant_oh[cand] = 1'b1;
            end
        end
        if (flush || !reset_n) begin
            grant_oh = '0;
            accept   = 1'b0;
        end
    end

    assign ptr_inc = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef PAL_XPARENT_EN
    assign xp_hit = s1_valid_q && (pal_index_q == IDX_W'(XPARENT_IDX));
`else
    assign xp_hit = 1'b0;
`endif

    always_comb begin
        rr_ptr_d      = accept ? ptr_inc : rr_ptr_q;
        s1_valid_d    = accept;
        s1_tag_d      = grant_oh;
        // Palette address only moves on an accept so the ROM input never glitches.
        pal_index_d   = accept ? grant_index : pal_index_q;
        rsp_valid_d   = s1_valid_q;
        rsp_tag_d     = s1_tag_q;
        rsp_rgb_d     = s1_valid_q ? pal_rgb : rsp_rgb_q;
        rsp_xparent_d = xp_hit;
        if (flush) begin
            rr_ptr_d      = '0;
            s1_valid_d    = 1'b0;
            s1_tag_d      = '0;
            rsp_valid_d   = 1'b0;
            rsp_tag_d     = '0;
            rsp_rgb_d     = rsp_rgb_q;
            rsp_xparent_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_tag_q      <= '0;
            pal_index_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_rgb_q     <= '0;
            rsp_xparent_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            s1_valid_q    <= s1_valid_d;
            s1_tag_q      <= s1_tag_d;
            pal_index_q   <= pal_index_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_rgb_q     <= rsp_rgb_d;
            rsp_xparent_q <= rsp_xparent_d;
        end
    end

    assign req_ready   = grant_oh;
    assign pal_index   = pal_index_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_rgb     = rsp_rgb_q;
    assign rsp_xparent = rsp_xparent_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed scenarios plus randomized traffic against a queue-based reference.
module tb_palette_lookup_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_index;
    logic [3:0]  req_ready;
    logic [7:0]  pal_index;
    logic [11:0] pal_rgb;
    logic        rsp_valid;
    logic [3:0]  rsp_tag;
    logic [11:0] rsp_rgb;
    logic        rsp_xparent;

    logic [11:0] pal_mem [256];

    palette_lookup_arbiter dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .pal_index(pal_index), .pal_rgb(pal_rgb),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_rgb(rsp_rgb), .rsp_xparent(rsp_xparent)
    );

    always #5 clk = ~clk;
    assign pal_rgb = pal_mem[pal_index];

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [11:0] rgb;
        logic        xp;
    } exp_t;

    exp_t        expq [$];
    int          m_ptr;
    int          ecount;
    logic [11:0] last_rgb;
    logic [7:0]  last_pal;
    int          errors;
    int          checks;
    logic [3:0]  rdy_dummy;

`ifdef PAL_XPARENT_EN
    localparam logic XP_ON = 1'b1;
`else
    localparam logic XP_ON = 1'b0;
`endif

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    // One clock: drive inputs at the falling edge, check grant, clock, check response.
    task automatic step(input logic [3:0] v, input logic [31:0] idx, input logic fl,
                        output logic [3:0] rdy);
        int         g;
        logic [3:0] exp_rdy;
        logic [7:0] lidx;
        exp_t       e;
        req_valid = v;
        req_index = idx;
        flush     = fl;
        #1;
        g = fl ? -1 : model_grant(v);
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b (valid=%b flush=%b)", req_ready, exp_rdy, v, fl);
        end
        rdy = req_ready;
        @(posedge clk);
        ecount++;
        if (fl) begin
            expq.delete();
            m_ptr = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 4;
            lidx  = idx[g*8 +: 8];
            e.due = ecount + 1;
            e.tag = 4'(1 << g);
            e.rgb = pal_mem[lidx];
            e.xp  = XP_ON && (lidx == 8'h00);
            expq.push_back(e);
            last_pal = lidx;
        end
        #1;
        checks++;
        if (pal_index !== last_pal) begin
            errors++;
            $display("FAIL pal_index: got %h expected %h", pal_index, last_pal);
        end
        if (expq.size() > 0 && expq[0].due == ecount) begin
            e = expq.pop_front();
            last_rgb = e.rgb;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== e.tag || rsp_rgb !== e.rgb || rsp_xparent !== e.xp) begin
                errors++;
                $display("FAIL response: valid=%b tag=%b rgb=%h xp=%b expected 1 %b %h %b",
                         rsp_valid, rsp_tag, rsp_rgb, rsp_xparent, e.tag, e.rgb, e.xp);
            end
        end else begin
            checks++;
            if (rsp_valid !== 1'b0 || rsp_tag !== 4'b0000 || rsp_rgb !== last_rgb || rsp_xparent !== 1'b0) begin
                errors++;
                $display("FAIL idle: valid=%b tag=%b rgb=%h xp=%b expected 0 0000 %h 0",
                         rsp_valid, rsp_tag, rsp_rgb, rsp_xparent, last_rgb);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] v);
        reset_n   = 1'b0;
        req_valid = v;
        req_index = $urandom;
        flush     = 1'b0;
        #1;
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_rgb !== 12'h000 ||
                rsp_tag !== 4'b0000 || pal_index !== 8'h00 || rsp_xparent !== 1'b0) begin
                errors++;
                $display("FAIL reset: ready=%b valid=%b rgb=%h tag=%b pal=%h xp=%b expected all zero",
                         req_ready, rsp_valid, rsp_rgb, rsp_tag, pal_index, rsp_xparent);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        reset_n   = 1'b1;
        m_ptr     = 0;
        expq.delete();
        last_rgb  = 12'h000;
        last_pal  = 8'h00;
    endtask

    task automatic test_reset();
        do_reset(4'b1111);
    endtask

    task automatic test_single();
        do_reset(4'b0000);
        step(4'b0100, {8'h00, 8'h05, 8'h00, 8'h00}, 1'b0, rdy_dummy);
        step(4'b0000, 32'h0, 1'b0, rdy_dummy);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'b0100 || rsp_rgb !== 12'hAB6) begin
            errors++;
            $display("FAIL single: valid=%b tag=%b rgb=%h expected 1 0100 ab6", rsp_valid, rsp_tag, rsp_rgb);
        end
        step(4'b0000, 32'h0, 1'b0, rdy_dummy);
    endtask

    task automatic test_round_robin();
        logic [3:0] rdy;
        do_reset(4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, $urandom, 1'b0, rdy);
            checks++;
            if (rdy !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_order: cycle %0d ready=%b expected %b", i, rdy, 4'(1 << (i % 4)));
            end
        end
        step(4'b0000, 32'h0, 1'b0, rdy);
        step(4'b0000, 32'h0, 1'b0, rdy);
    endtask

    task automatic test_wrap();
        logic [3:0] rdy;
        do_reset(4'b0000);
        step(4'b0100, $urandom, 1'b0, rdy);
        step(4'b1001, {8'h77, 8'h00, 8'h00, 8'h11}, 1'b0, rdy);
        checks++;
        if (rdy !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: ready=%b expected 1000", rdy);
        end
        step(4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 1'b0, rdy);
        checks++;
        if (rdy !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: ready=%b expected 0001", rdy);
        end
        step(4'b0000, 32'h0, 1'b0, rdy);
        step(4'b0000, 32'h0, 1'b0, rdy);
    endtask

    task automatic test_flush();
        logic [3:0] rdy;
        do_reset(4'b0000);
        step(4'b0010, 32'h0000_2200, 1'b0, rdy);
        step(4'b1111, $urandom, 1'b1, rdy);
        step(4'b0000, 32'h0, 1'b0, rdy);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: rsp_valid=%b expected 0", rsp_valid);
        end
        step(4'b1111, $urandom, 1'b0, rdy);
        checks++;
        if (rdy !== 4'b0001) begin
            errors++;
            $display("FAIL flush_ptr: ready=%b expected 0001", rdy);
        end
        step(4'b0000, 32'h0, 1'b0, rdy);
        step(4'b0000, 32'h0, 1'b0, rdy);
    endtask

    task automatic test_xparent();
        do_reset(4'b0000);
        step(4'b0001, 32'h0000_0000, 1'b0, rdy_dummy);
        step(4'b0010, 32'h0000_3400, 1'b0, rdy_dummy);
        checks++;
        if (rsp_xparent !== XP_ON || rsp_tag !== 4'b0001) begin
            errors++;
            $display("FAIL xparent_hit: xp=%b tag=%b expected %b 0001", rsp_xparent, rsp_tag, XP_ON);
        end
        step(4'b0000, 32'h0, 1'b0, rdy_dummy);
        checks++;
        if (rsp_xparent !== 1'b0 || rsp_tag !== 4'b0010 || rsp_rgb !== pal_mem[8'h34]) begin
            errors++;
            $display("FAIL xparent_miss: xp=%b tag=%b rgb=%h expected 0 0010 %h",
                     rsp_xparent, rsp_tag, rsp_rgb, pal_mem[8'h34]);
        end
        step(4'b0000, 32'h0, 1'b0, rdy_dummy);
    endtask

    task automatic test_reset_midop();
        do_reset(4'b0000);
        step(4'b0001, 32'h0000_0012, 1'b0, rdy_dummy);
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b0, rdy_dummy);
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [31:0] pidx;
        logic [3:0]  rdy;
        logic        fl;
        do_reset(4'b0000);
        pend = 4'b0000;
        pidx = 32'h0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < 4; l++) begin
                if (!pend[l] && ($urandom_range(0, 1) == 1)) begin
                    pend[l] = 1'b1;
                    pidx[l*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                end
            end
            fl = ($urandom_range(0, 24) == 0);
            step(pend, pidx, fl, rdy);
            pend = pend & ~rdy;
        end
        step(4'b0000, 32'h0, 1'b0, rdy);
        step(4'b0000, 32'h0, 1'b0, rdy);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses never arrived expected 0", expq.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ecount = 0;
        m_ptr  = 0;
        for (int i = 0; i < 256; i++) pal_mem[i] = 12'($urandom);
        pal_mem[5] = 12'hAB6;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_flush();
        test_xparent();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
